pwm_compare_dt: RTL and testbench
=================================

PWM_COMPARE_DT -- requirements
Module: pwm_compare_dt

Interface
REQ-001 Parameter: CW, 16, carrier/compare width; matches the carrier generator output width.
REQ-002 Parameter: DTW, 10, dead-time counter width.
REQ-003 Port: clk  in  1  clock; all state changes on rising edge.
REQ-004 Port: reset  in  1  reset, asynchronous, active-high.
REQ-005 Port: carrier  in  CW  carrier from the carrier generator, unsigned.
REQ-006 Port: period  in  CW  same period value driven to the carrier generator.
REQ-007 Port: compare  in  CW  requested compare value, unsigned.
REQ-008 Port: deadtime  in  DTW  dead time in clk cycles.
REQ-009 Port: update_mode  in  2  shadow load: 00 immediate, 01 at carrier==0, 10 at carrier==period, 11 at either.
REQ-010 Port: pwm_en  in  1  output enable.
REQ-011 Port: fault  in  1  synchronous kill request.
REQ-012 Port: pwm_h  out  1  high-side gate, registered.
REQ-013 Port: pwm_l  out  1  low-side gate, registered.
REQ-014 Port: load_evt  out  1  one-cycle pulse when compare_sh loaded in modes 01/10/11.
REQ-015 Port: fault_flag  out  1  high while in S_FAULT.

Function
REQ-016 compare_sh SHALL load compare on the load condition of update_mode, evaluated on carrier/period of the current cycle; it SHALL also load every cycle while state is S_OFF.
REQ-017 carrier==0 and carrier==period in the same cycle (period==0) SHALL produce a single load and a single load_evt pulse.
REQ-018 ref = (carrier < compare_sh), unsigned CW-bit compare, registered into ref_q (1-cycle latency).
REQ-019 compare_sh==0 -> ref_q constantly 0; compare_sh>period -> ref_q constantly 1.
REQ-020 FSM states: S_OFF, S_DT_H, S_H_ON, S_DT_L, S_L_ON, S_FAULT; pwm_h=1 only in S_H_ON, pwm_l=1 only in S_L_ON, both flops updated on the same edge as state.
REQ-021 S_OFF: pwm_en=1 and fault=0 -> S_DT_H if ref_q=1, else S_DT_L.
REQ-022 S_L_ON: ref_q=1 -> S_DT_H; S_H_ON: ref_q=0 -> S_DT_L.
REQ-023 On entry to S_DT_H/S_DT_L, dt_cnt SHALL load deadtime-1, decrement each cycle; exit to S_H_ON/S_L_ON on the cycle after dt_cnt==0, giving exactly deadtime cycles with both outputs low.
REQ-024 deadtime==0: S_L_ON<->S_H_ON directly in one edge, no dead state entered; outputs never both high.
REQ-025 ref_q reversing during S_DT_H SHALL move to S_DT_L (and vice versa) with dt_cnt reloaded; a pulse shorter than deadtime is swallowed.
REQ-026 deadtime is sampled only on dead-state entry; changes mid-count take effect at the next entry.
REQ-027 pwm_en=0 in any state except S_FAULT -> S_OFF on next edge.
REQ-028 fault=1 in any state -> S_FAULT on next edge (priority over pwm_en and ref_q); S_FAULT exits to S_OFF only when fault=0 and pwm_en=0.
REQ-029 Edge latency: carrier crossing at cycle N -> ref_q at N+1 -> first output change at N+2.

Reset
REQ-030 During reset: state=S_OFF, pwm_h=0, pwm_l=0, load_evt=0, fault_flag=0, compare_sh=0, ref_q=0, dt_cnt=0.
REQ-031 Reset asserted mid-operation SHALL drive both outputs low asynchronously; after release the FSM restarts from S_OFF per REQ-021.

Verification
REQ-032 Up/down carrier period=100, compare=40, deadtime=5, mode 01 -> pwm_h high while carrier<40 after 5-cycle both-low gap, pwm_l complementary, never both high.
REQ-033 compare changed 40->70 mid-period, mode 01 -> duty unchanged until carrier==0, load_evt pulses once there, then new duty.
REQ-034 deadtime=0, compare=50 -> pwm_h/pwm_l swap on a single edge, 2 cycles after crossing.
REQ-035 deadtime=10, compare giving a 4-cycle ref_q pulse -> pwm_h stays 0, pwm_l resumes after 10 cycles.
REQ-036 fault=1 while S_H_ON -> both low next edge, fault_flag=1; held until fault=0 and pwm_en=0, then S_OFF.
REQ-037 compare=0 -> pwm_l constant 1; compare=period+1 -> pwm_h constant 1; async reset mid-S_H_ON -> pwm_h=0 immediately.

Source files
------------

// File: rtl/pwm_compare_dt.sv
// Compare-based PWM generator with shadowed compare register, complementary
// high/low gate outputs, programmable dead time and a latched fault state.
module pwm_compare_dt #(
  parameter int unsigned CW  = 16,
  parameter int unsigned DTW = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [CW-1:0]  carrier,
  input  logic [CW-1:0]  period,
  input  logic [CW-1:0]  compare,
  input  logic [DTW-1:0] deadtime,
  input  logic [1:0]     update_mode,
  input  logic           pwm_en,
  input  logic           fault,
  output logic           pwm_h,
  output logic           pwm_l,
  output logic           load_evt,
  output logic           fault_flag
);

  typedef enum logic [2:0] {
    S_OFF,
    S_DT_H,
    S_H_ON,
    S_DT_L,
    S_L_ON,
    S_FAULT
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [CW-1:0]  compare_sh;
  logic           ref_q;
  logic [DTW-1:0] dt_cnt;
  logic [DTW-1:0] dt_nx;
  logic           at_zero_c;
  logic           at_period_c;
  logic           evt_c;
  logic           load_c;
  logic           go_h_c;
  logic           go_l_c;
  logic           pwm_h_nx;
  logic           pwm_l_nx;
  logic           fault_flag_nx;

  // Shadow-load condition; period==0 makes both hits coincide into one event
  always_comb begin
    at_zero_c   = (carrier == '0);
    at_period_c = (carrier == period);
    case (update_mode)
      2'b01:   evt_c = at_zero_c;
      2'b10:   evt_c = at_period_c;
      2'b11:   evt_c = at_zero_c | at_period_c;
      default: evt_c = 1'b0;
    endcase
    load_c = (update_mode == 2'b00) || evt_c || (state == S_OFF);
  end

  // Compare shadow register, registered reference and load pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      compare_sh <= '0;
      ref_q      <= 1'b0;
      load_evt   <= 1'b0;
    end else begin
      if (load_c) begin
        compare_sh <= compare;
      end
      ref_q    <= (carrier < compare_sh);
      load_evt <= evt_c;
    end
  end

  // Next-state, dead-time counter and next-output logic
  always_comb begin
    state_nx      = state;
    dt_nx         = dt_cnt;
    go_h_c        = 1'b0;
    go_l_c        = 1'b0;
    pwm_h_nx      = 1'b0;
    pwm_l_nx      = 1'b0;
    fault_flag_nx = 1'b0;

    case (state)
      S_OFF: begin
        if (pwm_en) begin
          if (ref_q) go_h_c = 1'b1;
          else       go_l_c = 1'b1;
        end
      end
      S_L_ON: begin
        if (ref_q) go_h_c = 1'b1;
      end
      S_H_ON: begin
        if (!ref_q) go_l_c = 1'b1;
      end
      S_DT_H: begin
        if (!ref_q)              go_l_c   = 1'b1;
        else if (dt_cnt == '0)   state_nx = S_H_ON;
        else                     dt_nx    = dt_cnt - DTW'(1);
      end
      S_DT_L: begin
        if (ref_q)               go_h_c   = 1'b1;
        else if (dt_cnt == '0)   state_nx = S_L_ON;
        else                     dt_nx    = dt_cnt - DTW'(1);
      end
      S_FAULT: begin
        if (!fault && !pwm_en) state_nx = S_OFF;
      end
      default: state_nx = S_OFF;
    endcase

    // Zero dead time swaps sides directly without visiting a dead state
    if (go_h_c) begin
      if (deadtime == '0) begin
        state_nx = S_H_ON;
      end else begin
        state_nx = S_DT_H;
        dt_nx    = deadtime - DTW'(1);
      end
    end
    if (go_l_c) begin
      if (deadtime == '0) begin
        state_nx = S_L_ON;
      end else begin
        state_nx = S_DT_L;
        dt_nx    = deadtime - DTW'(1);
      end
    end

    if (!pwm_en && (state != S_FAULT)) state_nx = S_OFF;
    if (fault)                         state_nx = S_FAULT;

    if ((state_nx != S_DT_H) && (state_nx != S_DT_L)) dt_nx = '0;

    pwm_h_nx      = (state_nx == S_H_ON);
    pwm_l_nx      = (state_nx == S_L_ON);
    fault_flag_nx = (state_nx == S_FAULT);
  end

  // State, counter and gate output registers share one edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_OFF;
      dt_cnt     <= '0;
      pwm_h      <= 1'b0;
      pwm_l      <= 1'b0;
      fault_flag <= 1'b0;
    end else begin
      state      <= state_nx;
      dt_cnt     <= dt_nx;
      pwm_h      <= pwm_h_nx;
      pwm_l      <= pwm_l_nx;
      fault_flag <= fault_flag_nx;
    end
  end

endmodule

// File: tb/tb_pwm_compare_dt.sv
// Directed bench for pwm_compare_dt: a triangular carrier is driven by the
// bench and gate transitions are tagged with the carrier value sampled there.
module tb_pwm_compare_dt;

  localparam int unsigned CW  = 16;
  localparam int unsigned DTW = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic [CW-1:0]  carrier;
  logic [CW-1:0]  period;
  logic [CW-1:0]  compare;
  logic [DTW-1:0] deadtime;
  logic [1:0]     update_mode;
  logic           pwm_en;
  logic           fault;
  logic           pwm_h;
  logic           pwm_l;
  logic           load_evt;
  logic           fault_flag;

  pwm_compare_dt #(.CW(CW), .DTW(DTW)) dut (
    .clk         (clk),
    .reset       (reset),
    .carrier     (carrier),
    .period      (period),
    .compare     (compare),
    .deadtime    (deadtime),
    .update_mode (update_mode),
    .pwm_en      (pwm_en),
    .fault       (fault),
    .pwm_h       (pwm_h),
    .pwm_l       (pwm_l),
    .load_evt    (load_evt),
    .fault_flag  (fault_flag)
  );

  always #5 clk = ~clk;

  int   n_chk;
  int   n_fail;
  logic up;
  logic run_tri;
  int   h_cnt, l_cnt, load_cnt, both_total;
  int   h_rise_c, h_fall_c, l_rise_c, l_fall_c, load_c;
  logic ph, pl;

  // Single comparison point: counts and reports
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic clear_rec();
    h_cnt    = 0;
    l_cnt    = 0;
    load_cnt = 0;
    h_rise_c = -1;
    h_fall_c = -1;
    l_rise_c = -1;
    l_fall_c = -1;
    load_c   = -1;
  endtask

  // One clock: sample outputs after the edge, record, then advance carrier
  task automatic tick();
    @(posedge clk);
    #1;
    if (pwm_h) h_cnt++;
    if (pwm_l) l_cnt++;
    if (pwm_h && pwm_l) both_total++;
    if (load_evt) begin
      load_cnt++;
      load_c = int'(carrier);
    end
    if (pwm_h && !ph && h_rise_c < 0) h_rise_c = int'(carrier);
    if (!pwm_h && ph && h_fall_c < 0) h_fall_c = int'(carrier);
    if (pwm_l && !pl && l_rise_c < 0) l_rise_c = int'(carrier);
    if (!pwm_l && pl && l_fall_c < 0) l_fall_c = int'(carrier);
    ph = pwm_h;
    pl = pwm_l;
    if (run_tri) begin
      if (up) begin
        if (carrier >= period) begin
          up      = 1'b0;
          carrier = carrier - 16'd1;
        end else begin
          carrier = carrier + 16'd1;
        end
      end else begin
        if (carrier == '0) begin
          up      = 1'b1;
          carrier = carrier + 16'd1;
        end else begin
          carrier = carrier - 16'd1;
        end
      end
    end
  endtask

  task automatic run_until(input string tag, input int val, input logic dir_up);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      tick();
      if (int'(carrier) == val && up == dir_up) hit = 1'b1;
    end
    check_eq(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; both_total = 0;
    ph = 1'b0; pl = 1'b0;
    reset = 1'b1;
    carrier = '0; up = 1'b1; run_tri = 1'b0;
    period = 16'd100; compare = 16'd40; deadtime = 10'd5;
    update_mode = 2'b01; pwm_en = 1'b0; fault = 1'b0;
    clear_rec();

    repeat (3) tick();
    check_eq("rst_pwm_h", 32'(pwm_h), 32'd0);
    check_eq("rst_pwm_l", 32'(pwm_l), 32'd0);
    check_eq("rst_load_evt", 32'(load_evt), 32'd0);
    check_eq("rst_fault_flag", 32'(fault_flag), 32'd0);

    // Up/down carrier, compare 40, dead time 5, load at zero
    @(negedge clk);
    reset = 1'b0;
    run_tri = 1'b1;
    pwm_en = 1'b1;
    repeat (400) tick();
    run_until("a_sync", 60, 1'b1);
    clear_rec();
    repeat (200) tick();
    check_eq("a_h_cnt", 32'(h_cnt), 32'd74);
    check_eq("a_l_cnt", 32'(l_cnt), 32'd116);
    check_eq("a_l_fall", 32'(l_fall_c), 32'd38);
    check_eq("a_h_rise", 32'(h_rise_c), 32'd33);
    check_eq("a_h_fall", 32'(h_fall_c), 32'd41);
    check_eq("a_l_rise", 32'(l_rise_c), 32'd46);
    check_eq("a_load_cnt", 32'(load_cnt), 32'd1);
    check_eq("a_load_at", 32'(load_c), 32'd0);

    // Compare changed mid-period: old duty holds until carrier reaches zero
    compare = 16'd70;
    clear_rec();
    run_until("b_sync1", 20, 1'b0);
    check_eq("b_old_l_fall", 32'(l_fall_c), 32'd38);
    check_eq("b_old_h_rise", 32'(h_rise_c), 32'd33);
    check_eq("b_no_load", 32'(load_cnt), 32'd0);
    clear_rec();
    run_until("b_sync2", 50, 1'b0);
    check_eq("b_load_cnt", 32'(load_cnt), 32'd1);
    check_eq("b_load_at", 32'(load_c), 32'd0);
    check_eq("b_h_fall", 32'(h_fall_c), 32'd71);
    check_eq("b_l_rise", 32'(l_rise_c), 32'd76);
    check_eq("b_l_fall", 32'(l_fall_c), 32'd68);
    check_eq("b_h_rise", 32'(h_rise_c), 32'd63);

    // Zero dead time: direct swap two cycles after the crossing
    deadtime = 10'd0;
    compare = 16'd50;
    run_until("c_sync1", 60, 1'b1);
    run_until("c_sync2", 60, 1'b1);
    clear_rec();
    repeat (200) tick();
    check_eq("c_h_cnt", 32'(h_cnt), 32'd99);
    check_eq("c_l_cnt", 32'(l_cnt), 32'd101);
    check_eq("c_h_rise", 32'(h_rise_c), 32'd48);
    check_eq("c_l_fall", 32'(l_fall_c), 32'd48);
    check_eq("c_h_fall", 32'(h_fall_c), 32'd51);
    check_eq("c_l_rise", 32'(l_rise_c), 32'd51);

    // Short reference pulse is swallowed by a 10-cycle dead time
    run_tri = 1'b0;
    pwm_en = 1'b0;
    tick();
    deadtime = 10'd10;
    update_mode = 2'b00;
    compare = 16'd50;
    carrier = 16'd60;
    repeat (2) tick();
    pwm_en = 1'b1;
    repeat (20) tick();
    check_eq("d_l_on", 32'(pwm_l), 32'd1);
    check_eq("d_h_off", 32'(pwm_h), 32'd0);
    clear_rec();
    carrier = 16'd10;
    repeat (4) tick();
    carrier = 16'd60;
    repeat (26) tick();
    check_eq("d_h_cnt", 32'(h_cnt), 32'd0);
    check_eq("d_l_cnt", 32'(l_cnt), 32'd16);

    // Fault while high side is on, latched until fault and enable drop
    deadtime = 10'd2;
    carrier = 16'd10;
    repeat (10) tick();
    check_eq("e_h_on", 32'(pwm_h), 32'd1);
    fault = 1'b1;
    tick();
    check_eq("e_h_kill", 32'(pwm_h), 32'd0);
    check_eq("e_l_kill", 32'(pwm_l), 32'd0);
    check_eq("e_flag_set", 32'(fault_flag), 32'd1);
    fault = 1'b0;
    clear_rec();
    repeat (5) tick();
    check_eq("e_flag_hold", 32'(fault_flag), 32'd1);
    check_eq("e_hold_h_cnt", 32'(h_cnt), 32'd0);
    check_eq("e_hold_l_cnt", 32'(l_cnt), 32'd0);
    pwm_en = 1'b0;
    tick();
    check_eq("e_flag_clr", 32'(fault_flag), 32'd0);
    pwm_en = 1'b1;
    repeat (2) tick();
    check_eq("e_restart_dt", 32'(pwm_h), 32'd0);
    tick();
    check_eq("e_restart_h", 32'(pwm_h), 32'd1);

    // Asynchronous reset while high side is on
    #2;
    reset = 1'b1;
    #1;
    check_eq("r_async_h", 32'(pwm_h), 32'd0);
    check_eq("r_async_l", 32'(pwm_l), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) tick();
    check_eq("r_restart_dt", 32'(pwm_h), 32'd0);
    tick();
    check_eq("r_restart_h", 32'(pwm_h), 32'd1);

    // Compare extremes with immediate loading
    run_tri = 1'b1;
    carrier = '0;
    up = 1'b1;
    deadtime = 10'd3;
    compare = 16'd0;
    repeat (20) tick();
    clear_rec();
    repeat (200) tick();
    check_eq("f_zero_l_cnt", 32'(l_cnt), 32'd200);
    check_eq("f_zero_h_cnt", 32'(h_cnt), 32'd0);
    check_eq("f_mode00_no_evt", 32'(load_cnt), 32'd0);
    compare = 16'd101;
    repeat (20) tick();
    clear_rec();
    repeat (200) tick();
    check_eq("f_over_h_cnt", 32'(h_cnt), 32'd200);
    check_eq("f_over_l_cnt", 32'(l_cnt), 32'd0);

    // Load events at both carrier ends, then at period only
    update_mode = 2'b11;
    compare = 16'd40;
    clear_rec();
    repeat (200) tick();
    check_eq("g_mode11_cnt", 32'(load_cnt), 32'd2);
    update_mode = 2'b10;
    clear_rec();
    repeat (200) tick();
    check_eq("g_mode10_cnt", 32'(load_cnt), 32'd1);
    check_eq("g_mode10_at", 32'(load_c), 32'd100);

    check_eq("never_both_high", 32'(both_total), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
